// File: rtl/vga_timing.sv
// Raster timing generator: free-running h/v counters with registered decodes of
// sync, display-enable, active-area coordinates, line/frame markers and a frame counter.
module vga_timing #(
  parameter int unsigned H        = 1280,
  parameter int unsigned H_FP     = 48,
  parameter int unsigned H_SYNC   = 112,
  parameter int unsigned H_BP     = 248,
  parameter int unsigned V        = 1024,
  parameter int unsigned V_FP     = 1,
  parameter int unsigned V_SYNC   = 3,
  parameter int unsigned V_BP     = 38,
  parameter logic        SYNC_POL = 1'b1
) (
  input  logic        VGA_CLK,
  input  logic        reset,
  output logic        hsync,
  output logic        vsync,
  output logic        disp_en,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        line_start,
  output logic        frame_start,
  output logic [7:0]  frame_cnt
);

  localparam int unsigned H_TOTAL = H + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_ACT  = 11'(H);
  localparam logic [10:0] HS_BEG = 11'(H + H_FP);
  localparam logic [10:0] HS_END = 11'(H + H_FP + H_SYNC - 1);
  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_ACT  = 11'(V);
  localparam logic [10:0] VS_BEG = 11'(V + V_FP);
  localparam logic [10:0] VS_END = 11'(V + V_FP + V_SYNC - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);

  logic [10:0] h_cnt_q, h_cnt_d;
  logic [10:0] v_cnt_q, v_cnt_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        disp_en_q, disp_en_d;
  logic [10:0] x_q, x_d;
  logic [10:0] y_q, y_d;
  logic        line_start_q, line_start_d;
  logic        frame_start_q, frame_start_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;

  // NOTE: every signal gets a default at the top of the block so no path leaves it unassigned (no latch).
  always_comb begin
    h_cnt_d = h_cnt_q + 11'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 11'd1;
    end

    // Decodes use the pre-increment counters, so outputs trail the counters by one clock.
    disp_en_d     = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    x_d           = disp_en_d ? h_cnt_q : '0;
    y_d           = disp_en_d ? v_cnt_q : '0;
    hsync_d       = ((h_cnt_q >= HS_BEG) && (h_cnt_q <= HS_END)) ? SYNC_POL : ~SYNC_POL;
    vsync_d       = ((v_cnt_q >= VS_BEG) && (v_cnt_q <= VS_END)) ? SYNC_POL : ~SYNC_POL;
    line_start_d  = (h_cnt_q == '0);
    frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
    frame_cnt_d   = frame_start_d ? frame_cnt_q + 8'd1 : frame_cnt_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge VGA_CLK or negedge reset) begin
    if (!reset) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      disp_en_q     <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      disp_en_q     <= disp_en_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign disp_en     = disp_en_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a default-timing instance for line-level checks and mid-line reset,
// and a small-timing instance (14x7, negative syncs) for frame wrap and frame_cnt rollover.
module tb_vga_timing;

  typedef struct packed {
    logic        de;
    logic [10:0] x;
    logic [10:0] y;
    logic        hs;
    logic        vs;
    logic        ls;
    logic        fs;
    logic [7:0]  fc;
  } outs_t;

  typedef struct {
    int    n;
    outs_t exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_def_n, rst_sm_n;

  logic        d_hs, d_vs, d_de, d_ls, d_fs;
  logic [10:0] d_x, d_y;
  logic [7:0]  d_fc;
  logic        s_hs, s_vs, s_de, s_ls, s_fs;
  logic [10:0] s_x, s_y;
  logic [7:0]  s_fc;
  outs_t       d_o, s_o;

  assign d_o = {d_de, d_x, d_y, d_hs, d_vs, d_ls, d_fs, d_fc};
  assign s_o = {s_de, s_x, s_y, s_hs, s_vs, s_ls, s_fs, s_fc};

  vga_timing u_def (
    .VGA_CLK(clk), .reset(rst_def_n), .hsync(d_hs), .vsync(d_vs), .disp_en(d_de),
    .x(d_x), .y(d_y), .line_start(d_ls), .frame_start(d_fs), .frame_cnt(d_fc)
  );

  vga_timing #(
    .H(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b0)
  ) u_sm (
    .VGA_CLK(clk), .reset(rst_sm_n), .hsync(s_hs), .vsync(s_vs), .disp_en(s_de),
    .x(s_x), .y(s_y), .line_start(s_ls), .frame_start(s_fs), .frame_cnt(s_fc)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic vec_t mk(input int n, input logic de, input int xx, input int yy,
                              input logic hs, input logic vs, input logic ls, input logic fs,
                              input int fc);
    vec_t v;
    v.n   = n;
    v.exp = {de, 11'(xx), 11'(yy), hs, vs, ls, fs, 8'(fc)};
    return v;
  endfunction

  vec_t vecs[17];

  initial begin
    int cyc;
    int last_ls, last_fs, fs_cnt;
    int bad_ls, bad_fs, bad_frame, bad_y;
    int de_f, vs_f, ls_f;
    bit in_frame;
    logic [7:0] fc_a, fc_b, fc_c;
    int de_cnt, hs_cnt, hs_first, ls2, bad_x;
    outs_t mid;

    // Small config: edge n registers the decode of h=(n-1)%14, v=((n-1)/14)%7.
    // Syncs are active-low here, so 1 means idle.
    vecs[0]  = mk(1,   1, 0, 0, 1, 1, 1, 1, 1);
    vecs[1]  = mk(8,   1, 7, 0, 1, 1, 0, 0, 1);
    vecs[2]  = mk(9,   0, 0, 0, 1, 1, 0, 0, 1);
    vecs[3]  = mk(11,  0, 0, 0, 0, 1, 0, 0, 1);
    vecs[4]  = mk(13,  0, 0, 0, 0, 1, 0, 0, 1);
    vecs[5]  = mk(14,  0, 0, 0, 1, 1, 0, 0, 1);
    vecs[6]  = mk(15,  1, 0, 1, 1, 1, 1, 0, 1);
    vecs[7]  = mk(18,  1, 3, 1, 1, 1, 0, 0, 1);
    vecs[8]  = mk(46,  1, 3, 3, 1, 1, 0, 0, 1);
    vecs[9]  = mk(57,  0, 0, 0, 1, 1, 1, 0, 1);
    vecs[10] = mk(71,  0, 0, 0, 1, 0, 1, 0, 1);
    vecs[11] = mk(81,  0, 0, 0, 0, 0, 0, 0, 1);
    vecs[12] = mk(84,  0, 0, 0, 1, 0, 0, 0, 1);
    vecs[13] = mk(85,  0, 0, 0, 1, 1, 1, 0, 1);
    vecs[14] = mk(98,  0, 0, 0, 1, 1, 0, 0, 1);
    vecs[15] = mk(99,  1, 0, 0, 1, 1, 1, 1, 2);
    vecs[16] = mk(100, 1, 1, 0, 1, 1, 0, 0, 2);

    rst_def_n = 1'b0;
    rst_sm_n  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("def_reset_state", d_o, outs_t'({1'b0, 11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0}));
    check("sm_reset_state",  s_o, outs_t'({1'b0, 11'd0, 11'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0}));

    // ---------------- small config: table vectors ----------------
    rst_sm_n = 1'b1;
    cyc = 0;
    for (int i = 0; i < 17; i++) begin
      while (cyc < vecs[i].n) begin
        @(posedge clk);
        cyc++;
      end
      @(negedge clk);
      check($sformatf("sm_vec_n%0d", vecs[i].n), s_o, vecs[i].exp);
    end

    // ---------------- small config: run past 256 frames ----------------
    last_ls = 99; last_fs = 99; fs_cnt = 0;
    bad_ls = 0; bad_fs = 0; bad_frame = 0; bad_y = 0;
    de_f = 0; vs_f = 0; ls_f = 0; in_frame = 1'b0;
    fc_a = '0; fc_b = '0; fc_c = '0;
    for (int n = 101; n <= 25089; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (s_fs) begin
        if (n - last_fs != 98) bad_fs++;
        if (!s_ls) bad_ls++;
        if (in_frame && (de_f != 32 || vs_f != 14 || ls_f != 7)) bad_frame++;
        in_frame = 1'b1;
        de_f = 0; vs_f = 0; ls_f = 0;
        last_fs = n;
        fs_cnt++;
      end
      if (s_ls) begin
        if (n - last_ls != 14) bad_ls++;
        last_ls = n;
        ls_f++;
      end
      if (s_de) de_f++;
      if (!s_vs) vs_f++;
      if (!s_de && (s_x != 0 || s_y != 0)) bad_y++;
      if (n == 24990) fc_a = s_fc;
      if (n == 24991) fc_b = s_fc;
      if (n == 25089) fc_c = s_fc;
    end
    check("sm_line_start_spacing", bad_ls, 0);
    check("sm_frame_start_spacing", bad_fs, 0);
    check("sm_frame_de_vs_ls_counts", bad_frame, 0);
    check("sm_xy_zero_when_blank", bad_y, 0);
    check("sm_frame_start_count", fs_cnt, 255);
    check("sm_fc_before_wrap", fc_a, 8'd255);
    check("sm_fc_wrap_to_0", fc_b, 8'd0);
    check("sm_fc_after_wrap", fc_c, 8'd1);
    rst_sm_n = 1'b0;

    // ---------------- default config: first line ----------------
    @(negedge clk);
    rst_def_n = 1'b1;
    de_cnt = 0; hs_cnt = 0; hs_first = -1; ls2 = -1; bad_x = 0;
    mid = '0;
    for (int n = 1; n <= 2389; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 1)
        check("def_first_edge", d_o, outs_t'({1'b1, 11'd0, 11'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1}));
      if (n <= 1688) begin
        if (d_de) begin
          de_cnt++;
          if (d_x != 11'(n - 1) || d_y != 0) bad_x++;
        end else if (d_x != 0 || d_y != 0) bad_x++;
        if (d_hs) begin
          hs_cnt++;
          if (hs_first < 0) hs_first = n;
        end
      end
      if (n > 1 && d_ls && ls2 < 0) ls2 = n;
      if (n == 2389) mid = d_o;
    end
    check("def_de_count_line0", de_cnt, 1280);
    check("def_x_ramp", bad_x, 0);
    check("def_hsync_width", hs_cnt, 112);
    check("def_hsync_offset", hs_first - 1, 1328);
    check("def_line_period", ls2 - 1, 1688);
    check("def_mid_line_decode", mid,
          outs_t'({1'b1, 11'd700, 11'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1}));

    // ---------------- default config: asynchronous reset mid-line ----------------
    #2 rst_def_n = 1'b0;
    #1 check("def_async_reset_immediate", d_o,
             outs_t'({1'b0, 11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0}));
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("def_reset_held", d_o, outs_t'({1'b0, 11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0}));
    rst_def_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("def_restart_decode", d_o,
          outs_t'({1'b1, 11'd0, 11'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1}));
    @(posedge clk);
    @(negedge clk);
    check("def_restart_second", d_o,
          outs_t'({1'b1, 11'd1, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1}));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
Name: vga_timing

Overview:
- Generates raster timing for the display pipeline: horizontal/vertical sync, display-enable and pixel coordinates.
- Sits directly upstream of the pixel colour stages (border/fill generators). Its `disp_en`, `x` and `y` outputs drive their inputs on the same `VGA_CLK`.
- Default timing is 1280x1024@60 Hz (108 MHz pixel clock, positive syncs).
- Also provides frame/line markers and a frame counter for animation logic.

Parameters:
- H, 1280, active pixels per line
- H_FP, 48, horizontal front porch (clocks)
- H_SYNC, 112, horizontal sync width (clocks)
- H_BP, 248, horizontal back porch (clocks)
- V, 1024, active lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 3, vertical sync width (lines)
- V_BP, 38, vertical back porch (lines)
- SYNC_POL, 1'b1, asserted level of hsync/vsync (1 = positive)
- Derived, not overridable: H_TOTAL = H+H_FP+H_SYNC+H_BP (1688); V_TOTAL = V+V_FP+V_SYNC+V_BP (1066).

Ports:
- VGA_CLK  in  1  pixel clock; all logic on posedge
- reset  in  1  asynchronous, active-low reset
- hsync  out  1  horizontal sync, level SYNC_POL when asserted
- vsync  out  1  vertical sync, level SYNC_POL when asserted
- disp_en  out  1  high while the current pixel is in the active area
- x  out  11  active-area column, 0..H-1; 0 when disp_en=0
- y  out  11  active-area row, 0..V-1; 0 when disp_en=0
- line_start  out  1  one-cycle pulse at h_cnt=0 of every line (all V_TOTAL lines)
- frame_start  out  1  one-cycle pulse at h_cnt=0, v_cnt=0
- frame_cnt  out  8  frames started since reset, modulo 256

Behaviour:
- Internal counters:
  - h_cnt, 11 bits: 0..H_TOTAL-1, then wraps to 0.
  - v_cnt, 11 bits: advances only when h_cnt = H_TOTAL-1, wraps V_TOTAL-1 -> 0.
  - Line and frame wrap on the same edge when both counters are at terminal count.
- Output registering:
  - All outputs are registered decodes of the pre-increment counter values, so outputs lag the counters by exactly one clock.
  - No combinational paths from counters to outputs.
- Decode rules, for counter values (h, v):
  - disp_en = (h < H) && (v < V)
  - x = disp_en ? h : 0; y = disp_en ? v : 0
  - hsync asserted iff H+H_FP <= h <= H+H_FP+H_SYNC-1 (default 1328..1439)
  - vsync asserted iff V+V_FP <= v <= V+V_FP+V_SYNC-1 (default 1025..1027), independent of h
  - line_start = (h == 0); frame_start = (h == 0 && v == 0)
  - frame_cnt increments by 1, wrapping 255 -> 0, on the same edge that registers frame_start=1.
- Reset (reset=0, asynchronous):
  - Counters = 0; disp_en = 0; x = 0; y = 0.
  - hsync = vsync = ~SYNC_POL.
  - line_start = frame_start = 0; frame_cnt = 0.
- First posedge after reset release:
  - Outputs decode (0,0): disp_en=1, x=0, y=0, line_start=1, frame_start=1, frame_cnt=1.
  - Counters advance to h=1.
- Reset asserted mid-line or mid-frame:
  - All outputs go to reset values immediately, with no clock needed.
  - Timing restarts from (0,0); no partial-frame state survives.
- Steady-state periods at default parameters:
  - Line period 1688 clocks; frame period 1688*1066 = 1,799,408 clocks.
  - disp_en high for exactly 1280 consecutive clocks on each of lines 0..1023, and low for all of lines 1024..1065.
- Width rule: H_TOTAL and V_TOTAL must be <= 2047. Out-of-range parameter sets are a configuration error and need not be detected.

Test Plan:
- Reset release, default params -> first posedge: disp_en=1, x=0, y=0, frame_start=1, frame_cnt=1; hsync=vsync=0 before that edge.
- Run one full line -> disp_en high 1280 clocks (x = 0..1279 incrementing by 1); hsync high exactly 112 clocks starting 1328 clocks after line_start; line_start spacing 1688 clocks.
- Run two full frames -> frame_start spacing 1,799,408 clocks; vsync high for 3*1688 = 5064 clocks starting at v=1025; 1,310,720 disp_en cycles per frame; y = 0 outside active area.
- Small config (H=8, H_FP=2, H_SYNC=3, H_BP=1, V=4, V_FP=1, V_SYNC=1, V_BP=1, SYNC_POL=0) -> line = 14 clocks, frame = 98 clocks, hsync low at h=10..12, vsync low for line v=5; after 256 frames frame_cnt wraps to 0, then 1.
- Assert reset at h=700, v=500 for 3 clocks, with no edge between assertion and check -> outputs at reset values immediately; after release, first edge reproduces the (0,0) decode and frame_cnt=1.
- Boundary check at h=H_TOTAL-1, v=V_TOTAL-1 -> next edge shows frame_start=1 and line_start=1 together; no extra or missing line_start at the frame wrap.
